// File: rtl/aim65_tty_rx_if.sv
// Byte stream from the AIM 65 TTY receiver to its consumer.
// master drives data/valid, slave drives ready.
interface aim65_tty_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/aim65_tty_rx.sv
// AIM 65 TTY serial receiver (8N1, idle high) with valid/ready byte output.
// Define AIM65_TTY_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module aim65_tty_rx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                 cpu_clk,
    input  logic                 reset,
    input  logic                 serial_in,
    aim65_tty_rx_if.master       rx,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_n;
    logic          s_meta, s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          push;
    logic          ferr_n;
    logic          pop;

    always_comb begin
        state_n = state;
        cnt_n   = cnt - 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = cnt;
                if (!s) begin
                    state_n = S_START;
                    cnt_n   = HALF_LOAD;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    if (!s) begin
                        state_n = S_DATA;
                        cnt_n   = FULL_LOAD;
                        idx_n   = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    shreg_n = {s, shreg[7:1]};
                    cnt_n   = FULL_LOAD;
                    if (idx == 3'd7) state_n = S_STOP;
                    else             idx_n   = idx + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    if (s) begin
                        push    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_n = cnt;
                if (s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            s_meta      <= 1'b1;
            s           <= 1'b1;
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            framing_err <= 1'b0;
        end else begin
            s_meta      <= serial_in;
            s           <= s_meta;
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            framing_err <= ferr_n;
        end
    end

    always_comb busy = (state != S_IDLE);
    always_comb pop  = rx.rx_valid && rx.rx_ready;

`ifdef AIM65_TTY_RX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, wr;

    always_comb begin
        full = (count == FULL_CNT);
        // A pop in the same cycle frees the slot, so a full buffer still accepts.
        wr   = push && (!full || pop);
    end

    always_ff @(posedge cpu_clk) begin
        if (wr) mem[wptr] <= shreg;
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (wr && !pop)      count <= count + 1'b1;
            else if (!wr && pop) count <= count - 1'b1;
        end
    end

    always_comb begin
        rx.rx_valid = (count != '0);
        rx.rx_data  = rx.rx_valid ? mem[rptr] : '0;
    end
`else
    logic [7:0] hold;
    logic       hold_valid;

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= push && hold_valid && !pop;
            if (push && (!hold_valid || pop)) begin
                hold       <= shreg;
                hold_valid <= 1'b1;
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        rx.rx_valid = hold_valid;
        rx.rx_data  = hold;
    end
`endif

endmodule

// File: tb/tb_aim65_tty_rx.sv
// Scoreboard bench for aim65_tty_rx: expected bytes queued as frames are sent,
// popped and compared at each handshake.
module tb_aim65_tty_rx;

    localparam int unsigned C = 16;

    logic cpu_clk   = 1'b0;
    logic reset     = 1'b1;
    logic serial_in = 1'b1;
    logic framing_err, overrun, busy;

    aim65_tty_rx_if rx ();

    aim65_tty_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(16)) dut (
        .cpu_clk     (cpu_clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .rx          (rx),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    int         errors   = 0;
    int         checks   = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         pop_cnt  = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_b;

    // Handshake monitor: inputs change just after posedge, so negedge sees the
    // values the next posedge will act on.
    always @(negedge cpu_clk) begin
        if (!reset) begin
            if (framing_err) ferr_cnt++;
            if (overrun)     ovr_cnt++;
            if (rx.rx_valid && rx.rx_ready) begin
                checks++;
                pop_cnt++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %02h, required no byte", rx.rx_data);
                end else begin
                    exp_b = sb.pop_front();
                    if (rx.rx_data !== exp_b) begin
                        errors++;
                        $display("FAIL sb_data: got %02h, required %02h", rx.rx_data, exp_b);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic line(input logic v, input int n);
        serial_in = v;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        line(1'b0, C);
        for (int i = 0; i < 8; i++) line(d[i], C);
        line(stop, C);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        rx.rx_ready = 1'b0;
        repeat (3) tick();
        checks += 5;
        if (rx.rx_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %b, required 0", rx.rx_valid); end
        if (rx.rx_data !== 8'h00)   begin errors++; $display("FAIL rst_data: got %02h, required 00", rx.rx_data); end
        if (framing_err !== 1'b0)   begin errors++; $display("FAIL rst_ferr: got %b, required 0", framing_err); end
        if (overrun !== 1'b0)       begin errors++; $display("FAIL rst_ovr: got %b, required 0", overrun); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        int p0 = pop_cnt, f0 = ferr_cnt, o0 = ovr_cnt;
        int n = 0;
        // 2 sync + 1 detect + half bit to start sample + 9 bits to stop sample.
        int lat_exp = 3 + C / 2 + 9 * C;
        rx.rx_ready = 1'b1;
        sb.push_back(8'h55);
        sb.push_back(8'hA3);
        fork
            begin
                send_frame(8'h55, 1'b1);
                send_frame(8'hA3, 1'b1);
                line(1'b1, C);
            end
            begin
                while (!rx.rx_valid && n < 400) begin
                    tick();
                    n++;
                end
            end
        join
        checks++;
        if (n != lat_exp) begin errors++; $display("FAIL b2b_latency: got %0d, required %0d", n, lat_exp); end
        wait_drain(4 * C);
        checks += 3;
        if (pop_cnt - p0 != 2)  begin errors++; $display("FAIL b2b_pops: got %0d, required 2", pop_cnt - p0); end
        if (ferr_cnt - f0 != 0) begin errors++; $display("FAIL b2b_ferr: got %0d, required 0", ferr_cnt - f0); end
        if (ovr_cnt - o0 != 0)  begin errors++; $display("FAIL b2b_ovr: got %0d, required 0", ovr_cnt - o0); end
    endtask

    task automatic test_glitch();
        int p0 = pop_cnt, f0 = ferr_cnt;
        int n = 0;
        rx.rx_ready = 1'b1;
        line(1'b0, 5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b, required 1", busy); end
        serial_in = 1'b1;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b, required 0", busy); end
        line(1'b1, 2 * C);
        checks += 3;
        if (pop_cnt - p0 != 0)  begin errors++; $display("FAIL glitch_pops: got %0d, required 0", pop_cnt - p0); end
        if (ferr_cnt - f0 != 0) begin errors++; $display("FAIL glitch_ferr: got %0d, required 0", ferr_cnt - f0); end
        if (rx.rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b, required 0", rx.rx_valid); end
    endtask

    task automatic test_framing();
        int p0 = pop_cnt, f0 = ferr_cnt;
        rx.rx_ready = 1'b1;
        sb.push_back(8'h42);
        send_frame(8'h41, 1'b0);
        line(1'b0, 40);
        line(1'b1, 2 * C);
        send_frame(8'h42, 1'b1);
        line(1'b1, C);
        wait_drain(4 * C);
        checks += 2;
        if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL frm_ferr: got %0d, required 1", ferr_cnt - f0); end
        if (pop_cnt - p0 != 1)  begin errors++; $display("FAIL frm_pops: got %0d, required 1", pop_cnt - p0); end
    endtask

    task automatic test_overrun();
        int o0 = ovr_cnt;
`ifdef AIM65_TTY_RX_FIFO_EN
        int ovr_exp = 1;
        int keep = 16;
`else
        int ovr_exp = 16;
        int keep = 1;
`endif
        rx.rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < keep) sb.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        line(1'b1, C);
        checks += 3;
        if (ovr_cnt - o0 != ovr_exp) begin errors++; $display("FAIL ovr_count: got %0d, required %0d", ovr_cnt - o0, ovr_exp); end
        if (rx.rx_valid !== 1'b1)    begin errors++; $display("FAIL ovr_valid: got %b, required 1", rx.rx_valid); end
        if (rx.rx_data !== 8'h00)    begin errors++; $display("FAIL ovr_head: got %02h, required 00", rx.rx_data); end
        repeat (3) tick();
        checks++;
        if (rx.rx_data !== 8'h00)    begin errors++; $display("FAIL ovr_stable: got %02h, required 00", rx.rx_data); end
        rx.rx_ready = 1'b1;
        wait_drain(40);
        tick();
        checks++;
        if (rx.rx_valid !== 1'b0)    begin errors++; $display("FAIL ovr_empty: got %b, required 0", rx.rx_valid); end
    endtask

    task automatic test_reset_midframe();
        int p0;
        logic [7:0] d = 8'h7E;
        rx.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        line(1'b1, C);
        checks++;
        if (rx.rx_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill: got %b, required 1", rx.rx_valid); end
        line(1'b0, C);
        for (int i = 0; i < 4; i++) line(d[i], C);
        line(d[4], C / 2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, required 1", busy); end
        reset = 1'b1;
        tick();
        checks += 3;
        if (rx.rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, required 0", rx.rx_valid); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        if (rx.rx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %02h, required 00", rx.rx_data); end
        reset = 1'b0;
        line(1'b1, 4 * C);
        p0 = pop_cnt;
        rx.rx_ready = 1'b1;
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        line(1'b1, C);
        wait_drain(4 * C);
        checks++;
        if (pop_cnt - p0 != 1) begin errors++; $display("FAIL mid_pops: got %0d, required 1", pop_cnt - p0); end
    endtask

    initial begin
        rx.rx_ready = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aim65_tty_rx.md
# aim65_tty_rx

Serial receiver for the AIM 65 TTY port: deserializes the monitor's bit-banged output (VIA `$A800` port B bit 2, 8N1, idle high) into bytes for a host-side console or debug sink. It sits beside the CPU/VIA core in `cpu_clk` domain. It is the receiving end of the line the firmware drives. It exposes a valid/ready byte stream with framing and overrun flags.

## Interface
- `CLKS_PER_BIT`, default 104: `cpu_clk` cycles per bit. Legal range is ≥ 4. 104 gives 9600 baud at 1 MHz.
- `FIFO_DEPTH`, default 16: byte buffer depth. Power of two. Used only when the FIFO is compiled in.
- `cpu_clk` in 1: clock.
- `reset` in 1: synchronous, active-high. The clock is `cpu_clk`.
- `serial_in` in 1: TTY line from the VIA PB2 output. Asynchronous to the receiver, idle high.
- `rx_data` out 8: byte at the head of the buffer.
- `rx_valid` out 1: `rx_data` holds an unread byte.
- `rx_ready` in 1: consumer accepts the byte.
- `framing_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the buffer is full.
- `busy` out 1: the receiver state is not IDLE.

## Operation
- `serial_in` passes through a 2-flop synchronizer initialized to 1. All logic uses the synchronized value `s`.
- The bit counter is `$clog2(CLKS_PER_BIT)` bits wide. The bit index is 3 bits wide. The shift register is 8 bits and shifts right, so the first data bit received is the LSB.
- State machine:
  - IDLE: when `s` is 0, go to START and load the counter with `CLKS_PER_BIT/2 - 1`.
  - START: when the counter reaches 0, sample `s`.
    - If `s` is 0, go to DATA, load `CLKS_PER_BIT - 1` and set bit index 0.
    - If `s` is 1, treat it as a glitch and go back to IDLE. Nothing is flagged.
  - DATA: each time the counter reaches 0, shift `s` into bit 7 and reload the counter. After bit index 7, go to STOP with the counter reloaded.
  - STOP: when the counter reaches 0, sample `s`.
    - If `s` is 1, push the byte and go to IDLE.
    - If `s` is 0, pulse `framing_err`, discard the byte and go to BREAK.
  - BREAK: wait for `s` to be 1, then go to IDLE. This stops a held-low line (break) from producing phantom bytes.
- Push with the buffer full and no pop in the same cycle: the new byte is dropped, `overrun` pulses and the buffer contents are unchanged.
- Pop: happens on a rising edge where `rx_valid && rx_ready`. `rx_ready` while `rx_valid` is 0 is ignored.
- Simultaneous push and pop with the buffer full: both take effect. There is no overrun.
- `rx_data` stays stable while `rx_valid && !rx_ready`.
- Reset values:
  - `rx_valid` = 0, `rx_data` = 0x00, `framing_err` = 0, `overrun` = 0, `busy` = 0.
  - State = IDLE and the buffer is empty.
  - Synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame and discards all buffered bytes. After reset deasserts, a line still low waits in IDLE→START. If the line is low at the half-bit sample, the receiver accepts a start bit and resynchronizes on the following frame through framing detection.

## Timing
- Input latency is 2 cycles (synchronizer).
- The start bit is sampled `CLKS_PER_BIT/2` cycles after the falling edge is detected. Data bit n is sampled `CLKS_PER_BIT*(n+1)` cycles after the start sample. The stop bit is sampled at `CLKS_PER_BIT*9`.
- `rx_valid` rises 1 cycle after the stop-bit sample edge when the buffer was empty.
- Back-to-back frames are supported. IDLE is re-entered in the same cycle as the stop sample, so a start edge half a bit later is caught. Tolerated baud mismatch is ±4 %.
- `framing_err` and `overrun` assert in the cycle after the stop sample, for exactly 1 cycle.
- `busy` is high from the cycle after the falling edge is detected until IDLE is re-entered.

## Configuration
- Macro: `AIM65_TTY_RX_FIFO_EN`.
- Defined: a `FIFO_DEPTH`-entry circular buffer with wrap-around read/write pointers and an occupancy count of `$clog2(FIFO_DEPTH)+1` bits. Full means count equals `FIFO_DEPTH`. `rx_data` shows the head entry. Empty means `rx_valid` is 0.
- Undefined: a single holding register (effective depth 1). `FIFO_DEPTH` is ignored. Overrun occurs on the second completed byte if the first has not been popped.

## Test plan
- `CLKS_PER_BIT`=16, send 0x55 then 0xA3 back-to-back with `rx_ready`=1 → two handshakes carrying 0x55, 0xA3. The first `rx_valid` rises 1 cycle after the stop sample. No error pulses.
- Low glitch on `serial_in` lasting 5 cycles (< half bit) → START aborts to IDLE. No `rx_valid`, no `framing_err`, `busy` falls within 10 cycles.
- Frame 0x41 with the stop bit forced to 0, then the line held low for 40 cycles, then 0x42 → one `framing_err` pulse, 0x41 discarded, only 0x42 delivered.
- With `rx_ready`=0, send 17 bytes 0x00–0x10 → with the FIFO: 16 bytes buffered, 1 `overrun` pulse, draining yields 0x00–0x0F. Without the FIFO: 0x00 held and 16 `overrun` pulses.
- Assert `reset` at data bit 4 of 0x7E with 3 bytes buffered → next cycle: `rx_valid`=0, `busy`=0, `rx_data`=0x00. A subsequent clean 0x7E is received correctly.
